// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite motion controller and the sprite ROM
// renderer.
//   POS_W / VEL_W      : widths of the position and velocity registers
//   SPRITE_W/SPRITE_H  : sprite bitmap size; must match the ROM geometry
//   motion_state_t     : vertical motion state, encoded as GROUND=0, RISING=1, FALLING=2
package sprite_pkg;

  localparam int unsigned POS_W    = 11;
  localparam int unsigned VEL_W    = 5;
  localparam int unsigned SPRITE_W = 40;
  localparam int unsigned SPRITE_H = 24;

  typedef enum logic [1:0] {
    GROUND  = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2
  } motion_state_t;

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Signal bundle between the frame/button sources and the motion controller.
//   frame_tick                    : one-cycle pulse at the start of vertical blanking
//   btn_left/btn_right/btn_jump   : button levels, already synchronised to clk
//   pos_x/pos_y                   : sprite top-left corner, to the renderer
//   airborne                      : high whenever state is not GROUND
//   state                         : vertical motion state
// master drives the inputs (frame timing / buttons); slave is the controller.
interface sprite_motion_ctrl_if;
  import sprite_pkg::*;

  logic              frame_tick;
  logic              btn_left;
  logic              btn_right;
  logic              btn_jump;
  logic [POS_W-1:0]  pos_x;
  logic [POS_W-1:0]  pos_y;
  logic              airborne;
  motion_state_t     state;

  modport master (
    output frame_tick, btn_left, btn_right, btn_jump,
    input  pos_x, pos_y, airborne, state
  );

  modport slave (
    input  frame_tick, btn_left, btn_right, btn_jump,
    output pos_x, pos_y, airborne, state
  );

endinterface

// File: rtl/sprite_motion_ctrl_jump_edge_latch.sv
// Jump request latch: a rising edge of btn_jump sets a sticky request, which
// every frame_tick clears.
//   clk, rst   : clock, asynchronous active-high reset
//   frame_tick : clears the request
//   btn_jump   : jump button level
//   req        : request seen by the current tick; this includes an edge
//                arriving in the same cycle as the tick
module jump_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic btn_jump,
  output logic req
);

  logic btn_prev;
  logic jump_req;
  logic jump_edge;

  assign jump_edge = btn_jump & ~btn_prev;
  assign req       = jump_req | jump_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev <= 1'b0;
      jump_req <= 1'b0;
    end else begin
      btn_prev <= btn_jump;
      jump_req <= frame_tick ? 1'b0 : req;
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position controller. Left/right buttons move the sprite
// horizontally. A jump/gravity state machine moves it vertically. Updates
// happen only when frame_tick is high. All outputs are registered and hold
// their values between ticks.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sprite_motion_ctrl_if.slave carrying frame_tick, the buttons,
//              and pos_x/pos_y/airborne/state
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned H_RES    = 640,
  parameter int unsigned SPRITE_W = sprite_pkg::SPRITE_W,
  parameter int unsigned START_X  = 300,
  parameter int unsigned GROUND_Y = 400,
  parameter int unsigned STEP_X   = 4,
  parameter int unsigned JUMP_V   = 12,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned MAX_FALL = 12
) (
  input logic                 clk,
  input logic                 rst,
  sprite_motion_ctrl_if.slave bus
);

  localparam logic [11:0] X_MAX = 12'(H_RES - SPRITE_W);

  logic [POS_W-1:0] pos_x, pos_y, x_next;
  logic [VEL_W-1:0] vel_y, vel_dec, vel_inc;
  logic [VEL_W:0]   vel_sum;
  logic [11:0]      x_wide, x_right, x_left, y_fall;
  logic             airborne, jump_req;
  motion_state_t    state;

  jump_edge_latch u_jump (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (bus.frame_tick),
    .btn_jump   (bus.btn_jump),
    .req        (jump_req)
  );

  // 12-bit intermediates keep every sum in range, so clamping happens
  // before truncation back to POS_W bits.
  always_comb begin
    x_wide  = 12'(pos_x);
    x_right = x_wide + 12'(STEP_X);
    if (x_right > X_MAX) x_right = X_MAX;
    x_left  = (x_wide < 12'(STEP_X)) ? '0 : x_wide - 12'(STEP_X);
    case ({bus.btn_right, bus.btn_left})
      2'b10:   x_next = x_right[POS_W-1:0];
      2'b01:   x_next = x_left[POS_W-1:0];
      default: x_next = pos_x;
    endcase

    vel_dec = (vel_y > VEL_W'(GRAVITY)) ? vel_y - VEL_W'(GRAVITY) : '0;
    vel_sum = {1'b0, vel_y} + (VEL_W + 1)'(GRAVITY);
    vel_inc = (vel_sum > (VEL_W + 1)'(MAX_FALL)) ? VEL_W'(MAX_FALL)
                                                 : vel_sum[VEL_W-1:0];
    y_fall  = 12'(pos_y) + 12'(vel_y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x    <= POS_W'(START_X);
      pos_y    <= POS_W'(GROUND_Y);
      vel_y    <= '0;
      state    <= GROUND;
      airborne <= 1'b0;
    end else if (bus.frame_tick) begin
      pos_x <= x_next;
      case (state)
        GROUND: begin
          if (jump_req) begin
            state    <= RISING;
            vel_y    <= VEL_W'(JUMP_V);
            airborne <= 1'b1;
          end
        end
        RISING: begin
          if (12'(vel_y) > 12'(pos_y)) begin
            pos_y <= '0;
            vel_y <= '0;
            state <= FALLING;
          end else begin
            pos_y <= pos_y - POS_W'(vel_y);
            vel_y <= vel_dec;
            if (vel_dec == '0) state <= FALLING;
          end
        end
        FALLING: begin
          if (y_fall >= 12'(GROUND_Y)) begin
            pos_y    <= POS_W'(GROUND_Y);
            vel_y    <= '0;
            state    <= GROUND;
            airborne <= 1'b0;
          end else begin
            pos_y <= y_fall[POS_W-1:0];
            vel_y <= vel_inc;
          end
        end
        default: begin
          state    <= GROUND;
          airborne <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pos_x    = pos_x;
  assign bus.pos_y    = pos_y;
  assign bus.airborne = airborne;
  assign bus.state    = state;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
module tb_sprite_motion_ctrl;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  sprite_motion_ctrl_if bus ();

  sprite_motion_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame tick: raised on a falling edge, captured by the next rising
  // edge, and dropped on the following falling edge, where outputs are sampled.
  task automatic tick();
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
  endtask

  task automatic jump_pulse();
    @(negedge clk) bus.btn_jump = 1'b1;
    @(negedge clk) bus.btn_jump = 1'b0;
  endtask

  int rise_y[12] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322};
  int fall_y[13] = '{322, 323, 325, 328, 332, 337, 343, 350, 358, 367, 377, 388, 400};

  initial begin
    int exp_x;
    logic [10:0] hx, hy;
    logic [1:0]  hs;

    bus.frame_tick = 1'b0;
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b0;
    bus.btn_jump   = 1'b0;

    // Reset with the clock stopped
    #2 rst = 1'b1;
    #1;
    chk("rst_pos_x", 32'(bus.pos_x), 300);
    chk("rst_pos_y", 32'(bus.pos_y), 400);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_airborne", 32'(bus.airborne), 0);
    clk_en = 1'b1;
    @(negedge clk) rst = 1'b0;

    // Right clamp: 300 + 4*i, saturating at 600
    bus.btn_right = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      exp_x = (300 + 4 * i > 600) ? 600 : 300 + 4 * i;
      chk("right_x", 32'(bus.pos_x), 32'(exp_x));
    end
    chk("right_y", 32'(bus.pos_y), 400);
    bus.btn_right = 1'b0;

    // Left clamp: 600 - 4*i, saturating at 0
    bus.btn_left = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      exp_x = (4 * i > 600) ? 0 : 600 - 4 * i;
      chk("left_x", 32'(bus.pos_x), 32'(exp_x));
    end

    // Both held: no motion. Start from 8 so a wrong direction would show.
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b1;
    tick(); tick();
    chk("pre_both_x", 32'(bus.pos_x), 8);
    bus.btn_left = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("both_x", 32'(bus.pos_x), 8);
    end
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;

    // Full jump, with a press while airborne that must be ignored
    jump_pulse();
    tick();
    chk("jump_state", 32'(bus.state), 1);
    chk("jump_y", 32'(bus.pos_y), 400);
    chk("jump_air", 32'(bus.airborne), 1);
    for (int i = 0; i < 12; i++) begin
      if (i == 3) jump_pulse();
      tick();
      chk("rise_y", 32'(bus.pos_y), 32'(rise_y[i]));
      chk("rise_state", 32'(bus.state), (i == 11) ? 2 : 1);
    end
    for (int i = 0; i < 13; i++) begin
      if (i == 5) jump_pulse();
      tick();
      chk("fall_y", 32'(bus.pos_y), 32'(fall_y[i]));
      chk("fall_le_ground", 32'(bus.pos_y <= 11'd400), 1);
      chk("fall_state", 32'(bus.state), (i == 12) ? 0 : 2);
    end
    chk("land_air", 32'(bus.airborne), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_rejump_state", 32'(bus.state), 0);
    end

    // btn_jump held through the whole jump and the landing
    @(negedge clk) bus.btn_jump = 1'b1;
    for (int i = 0; i < 26; i++) tick();
    chk("held_land_state", 32'(bus.state), 0);
    chk("held_land_y", 32'(bus.pos_y), 400);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_no_rejump", 32'(bus.state), 0);
    end
    @(negedge clk) bus.btn_jump = 1'b0;
    @(negedge clk);

    // Edge and tick in the same cycle
    bus.btn_jump = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.btn_jump = 1'b0;
    chk("same_cycle_state", 32'(bus.state), 1);
    for (int i = 0; i < 25; i++) tick();
    chk("same_cycle_land", 32'(bus.state), 0);
    chk("same_cycle_land_y", 32'(bus.pos_y), 400);

    // Hold between ticks. The jump toggling leaves a request pending.
    hx = bus.pos_x; hy = bus.pos_y; hs = bus.state;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      bus.btn_left  = 1'($urandom_range(0, 1));
      bus.btn_right = 1'($urandom_range(0, 1));
      bus.btn_jump  = 1'(i % 2);
    end
    chk("hold_x", 32'(bus.pos_x), 8);
    chk("hold_y", 32'(bus.pos_y), 32'(hy));
    chk("hold_state", 32'(bus.state), 32'(hs));
    chk("hold_x_same", 32'(bus.pos_x), 32'(hx));

    // Pending request starts a jump; reset once it reaches 350 while rising
    @(negedge clk);
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_jump = 1'b0;
    tick();
    chk("pend_jump_state", 32'(bus.state), 1);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_y", 32'(bus.pos_y), 350);
    chk("mid_state", 32'(bus.state), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_y", 32'(bus.pos_y), 400);
    chk("mid_rst_state", 32'(bus.state), 0);
    chk("mid_rst_x", 32'(bus.pos_x), 300);
    chk("mid_rst_air", 32'(bus.airborne), 0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("post_rst_x", 32'(bus.pos_x), 300);
    chk("post_rst_y", 32'(bus.pos_y), 400);
    chk("post_rst_state", 32'(bus.state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
